mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 105 ++++++++++
 tb/tb_mem_wb_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, extracts big-endian
// sub-word loads, flags misaligned loads and counts retired instructions.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [4:0]        in_wr_reg,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus8,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic [1:0]        in_byte_off,
  input  logic              stall,
  input  logic              flush,
  output logic              RegWrite,
  output logic [4:0]        writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              wb_valid,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  logic              isWordLoad;
  logic              misaligned;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [DATA_W-1:0] loadValue;
  logic [DATA_W-1:0] captureData;
  logic              captureWrite;

  always_comb begin
    // The reserved size encoding behaves as a full word.
    isWordLoad = (in_load_size != SIZE_HALF) && (in_load_size != SIZE_BYTE);
    misaligned = in_valid && (in_wb_sel == SEL_LOAD) &&
                 (((in_load_size == SIZE_HALF) && in_byte_off[0]) ||
                  (isWordLoad && (in_byte_off != 2'b00)));

    case (in_byte_off)
      2'd0:    loadByte = in_mem_data[31:24];
      2'd1:    loadByte = in_mem_data[23:16];
      2'd2:    loadByte = in_mem_data[15:8];
      default: loadByte = in_mem_data[7:0];
    endcase
    loadHalf = in_byte_off[1] ? in_mem_data[15:0] : in_mem_data[31:16];

    case (in_load_size)
      SIZE_HALF: loadValue = in_load_unsigned ? {{(DATA_W-16){1'b0}}, loadHalf}
                                              : {{(DATA_W-16){loadHalf[15]}}, loadHalf};
      SIZE_BYTE: loadValue = in_load_unsigned ? {{(DATA_W-8){1'b0}}, loadByte}
                                              : {{(DATA_W-8){loadByte[7]}}, loadByte};
      default:   loadValue = in_mem_data;
    endcase

    case (in_wb_sel)
      SEL_ALU:  captureData = in_alu_result;
      SEL_LOAD: captureData = misaligned ? '0 : loadValue;
      SEL_LINK: captureData = in_pc_plus8;
      default:  captureData = '0;
    endcase

    captureWrite = in_valid && in_reg_write && (in_wr_reg != 5'd0) &&
                   !misaligned && (in_wb_sel != 2'b11);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite     <= 1'b0;
      writeReg     <= '0;
      writeData    <= '0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      retired_cnt  <= '0;
    end else if (flush) begin
      // Flush kills the instruction but leaves the retired count alone.
      RegWrite     <= 1'b0;
      writeReg     <= '0;
      writeData    <= '0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else if (stall) begin
      misalign_err <= 1'b0;
    end else begin
      RegWrite     <= captureWrite;
      writeReg     <= in_wr_reg;
      writeData    <= captureData;
      wb_valid     <= in_valid;
      misalign_err <= misaligned;
      if (in_valid)
        retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed steps plus random traffic
// compared against a behavioural model of the write-back rules.
module tb_mem_wb_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_reg_write = 1'b0;
  logic [4:0]        in_wr_reg = '0;
  logic [1:0]        in_wb_sel = '0;
  logic [DATA_W-1:0] in_alu_result = '0;
  logic [DATA_W-1:0] in_mem_data = '0;
  logic [DATA_W-1:0] in_pc_plus8 = '0;
  logic [1:0]        in_load_size = '0;
  logic              in_load_unsigned = 1'b0;
  logic [1:0]        in_byte_off = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              RegWrite;
  logic [4:0]        writeReg;
  logic [DATA_W-1:0] writeData;
  logic              wb_valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  retired_cnt;

  mem_wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_wr_reg(in_wr_reg), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus8(in_pc_plus8), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_byte_off(in_byte_off), .stall(stall),
    .flush(flush), .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .wb_valid(wb_valid), .misalign_err(misalign_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit          mValid, mRW, mErr;
  int unsigned mReg, mData, mCnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(mRW));
    chk({tag, ".writeReg"}, 32'(writeReg), mReg);
    chk({tag, ".writeData"}, writeData, mData);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(mValid));
    chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(mErr));
    chk({tag, ".retired_cnt"}, 32'(retired_cnt), mCnt);
  endtask

  task automatic modelReset();
    mValid = 0; mRW = 0; mErr = 0; mReg = 0; mData = 0; mCnt = 0;
  endtask

  function automatic int unsigned loadValue();
    int unsigned mem, b, h;
    int unsigned off;
    mem = in_mem_data;
    off = in_byte_off;
    if (in_load_size == 2) begin
      b = (mem >> (8 * (3 - off))) % 256;
      if (!in_load_unsigned && b >= 128) return b + 32'hFFFFFF00;
      return b;
    end else if (in_load_size == 1) begin
      h = (off >= 2) ? mem % 65536 : mem / 65536;
      if (!in_load_unsigned && h >= 32768) return h + 32'hFFFF0000;
      return h;
    end
    return mem;
  endfunction

  // Apply one clock edge to the reference using the inputs present at that edge.
  task automatic modelEdge();
    bit mis;
    if (!reset) begin
      modelReset();
    end else if (flush) begin
      mValid = 0; mRW = 0; mReg = 0; mData = 0; mErr = 0;
    end else if (stall) begin
      mErr = 0;
    end else begin
      mis = in_valid && in_wb_sel == 1 &&
            ((in_load_size == 1 && in_byte_off % 2 == 1) ||
             ((in_load_size == 0 || in_load_size == 3) && in_byte_off != 0));
      mValid = in_valid;
      mReg = in_wr_reg;
      mErr = mis;
      mRW = in_valid && in_reg_write && in_wr_reg != 0 && !mis && in_wb_sel != 3;
      case (in_wb_sel)
        2'd0: mData = in_alu_result;
        2'd1: mData = mis ? 0 : loadValue();
        2'd2: mData = in_pc_plus8;
        default: mData = 0;
      endcase
      if (in_valid) mCnt = (mCnt + 1) % 65536;
    end
  endtask

  task automatic step(input string tag, input bit verbose);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
    if (verbose)
      $display("%s: v=%0b sel=%0d sz=%0d off=%0d st=%0b fl=%0b -> RegWrite=%0b writeReg=%0d writeData=0x%08h wb_valid=%0b err=%0b cnt=%0d",
               tag, in_valid, in_wb_sel, in_load_size, in_byte_off, stall, flush,
               RegWrite, writeReg, writeData, wb_valid, misalign_err, retired_cnt);
  endtask

  task automatic setOp(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel);
    in_valid = v; in_reg_write = rw; in_wr_reg = rd; in_wb_sel = sel;
    stall = 0; flush = 0;
  endtask

  task automatic randInputs(input bit allowCtl);
    in_valid = ($urandom_range(0, 9) != 0);
    in_reg_write = $urandom_range(0, 1);
    in_wr_reg = 5'($urandom);
    in_wb_sel = 2'($urandom);
    in_alu_result = $urandom;
    in_mem_data = $urandom;
    in_pc_plus8 = $urandom;
    in_load_size = 2'($urandom);
    in_load_unsigned = $urandom_range(0, 1);
    in_byte_off = 2'($urandom);
    stall = allowCtl && ($urandom_range(0, 5) == 0);
    flush = allowCtl && ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    modelReset();
    #2 reset = 1'b0;
    #1 checkAll("reset_state");
    step("reset_hold", 1);
    @(negedge clk);
    reset = 1'b1;
    #1;

    setOp(1, 1, 5'd5, 2'b00);
    in_alu_result = 32'h12345678;
    step("alu_capture", 1);
    chk("alu_capture.data_const", writeData, 32'h12345678);
    chk("alu_capture.cnt_const", 32'(retired_cnt), 32'd1);

    setOp(1, 1, 5'd7, 2'b01);
    in_mem_data = 32'h00F00000; in_load_size = 2'b10; in_byte_off = 2'd1; in_load_unsigned = 0;
    step("lb_signed", 1);
    chk("lb_signed.const", writeData, 32'hFFFFFFF0);
    in_load_unsigned = 1;
    step("lb_unsigned", 1);
    chk("lb_unsigned.const", writeData, 32'h000000F0);

    in_load_size = 2'b01; in_byte_off = 2'd1; in_mem_data = 32'hABCD1234;
    step("lh_misaligned", 1);
    chk("lh_misaligned.err", 32'(misalign_err), 32'd1);
    in_byte_off = 2'd2; in_load_unsigned = 0; in_mem_data = 32'h1234F00D;
    step("lh_aligned_after_err", 1);
    in_load_size = 2'b00; in_byte_off = 2'd3;
    step("lw_misaligned", 1);
    setOp(1, 1, 5'd0, 2'b00);
    step("rd_zero", 1);
    setOp(1, 1, 5'd3, 2'b11);
    step("reserved_sel", 1);

    setOp(1, 1, 5'd31, 2'b10);
    in_pc_plus8 = 32'h00400008;
    step("link_capture", 1);
    setOp(1, 1, 5'd9, 2'b00);
    in_alu_result = 32'hDEADBEEF;
    stall = 1;
    for (int i = 0; i < 3; i++) step($sformatf("stall_%0d", i), 1);
    chk("stall.data_const", writeData, 32'h00400008);
    flush = 1;
    step("stall_flush", 1);
    chk("stall_flush.valid_const", 32'(wb_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      randInputs(1);
      step($sformatf("rand_%0d", i), 1);
    end

    // Asynchronous reset between edges while a write is pending
    setOp(1, 1, 5'd4, 2'b00);
    in_alu_result = 32'h55AA55AA;
    step("pre_async_reset", 1);
    chk("pre_async_reset.rw", 32'(RegWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    stall = 1; flush = 1;
    step("reset_over_stall_flush", 1);
    @(negedge clk);
    reset = 1'b1;
    setOp(1, 1, 5'd6, 2'b00);
    in_alu_result = 32'h0BADF00D;
    #1;
    step("first_after_reset", 1);
    chk("first_after_reset.cnt", 32'(retired_cnt), 32'd1);

    // Counter wrap: bring the count to 0xFFFF, then one more capture.
    reset = 1'b0;
    #1 modelReset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      randInputs(0);
      in_valid = 1;
      step("wrap_fill", 0);
    end
    $display("wrap_fill: 65535 captures -> cnt=0x%04h", retired_cnt);
    chk("wrap_full", 32'(retired_cnt), 32'h0000FFFF);
    setOp(1, 1, 5'd2, 2'b00);
    step("wrap_over", 1);
    chk("wrap_zero", 32'(retired_cnt), 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
